// File: rtl/b12_kbd_pkg.sv
// Shared types and constants for the b12 keypad front end.
package b12_kbd_pkg;

  localparam int KEY_W               = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_CYCLES_DEF   = 64;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } kbd_state_t;

  function automatic logic [2:0] popcount(input logic [KEY_W-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/b12_debounce_cell.sv
// One raw button: 2-flop synchroniser, stability counter and debounced level.
module b12_debounce_cell
  import b12_kbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = ~stable_q;
      else                  cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the synchroniser is
  // reset too, so a button held through reset is debounced again from scratch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/b12_keypad_frontend.sv
// Debounces four keys plus start and resolves them into a one-hot key code.
// Optional auto-repeat of key_valid while a key is held: B12_KEY_AUTOREPEAT_EN.
module b12_keypad_frontend
  import b12_kbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] btn_raw,
  input  logic             start_raw,
  output logic [KEY_W-1:0] k,
  output logic             start,
  output logic             key_valid,
  output logic             conflict
);

  logic [KEY_W:0]   raw_all, stable_all;
  logic [KEY_W-1:0] sk;
  logic [2:0]       sk_count;

  assign raw_all = {start_raw, btn_raw};

  for (genvar i = 0; i <= KEY_W; i++) begin : g_cell
    b12_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .raw   (raw_all[i]),
      .stable(stable_all[i])
    );
  end

  assign sk       = stable_all[KEY_W-1:0];
  assign sk_count = popcount(sk);

  kbd_state_t       state_q, state_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic             key_valid_q, key_valid_d;
  logic             conflict_q, conflict_d;
  logic             start_q, start_d;
  logic             rep_pulse;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (sk_count == 3'd1) begin
          state_d = ARMED;
          code_d  = sk;
        end else if (sk_count >= 3'd2) begin
          state_d = LOCKED;
        end
      end
      ARMED: begin
        if (sk == '0)          state_d = IDLE;
        else if (sk != code_q) state_d = LOCKED;
      end
      LOCKED: if (sk == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change with it.
    k_d         = (state_d == ARMED) ? code_d : '0;
    key_valid_d = ((state_q == IDLE) && (state_d == ARMED)) || rep_pulse;
    conflict_d  = (state_d == LOCKED);
    start_d     = stable_all[KEY_W];
  end

`ifdef B12_KEY_AUTOREPEAT_EN
  localparam int               REP_W   = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Runs only while ARMED is held; any exit restarts the period.
  always_comb begin
    rep_d     = '0;
    rep_pulse = 1'b0;
    if ((state_q == ARMED) && (state_d == ARMED)) begin
      if (rep_q == REP_MAX) rep_pulse = 1'b1;
      else                  rep_d     = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES > 0);
  assign rep_pulse     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      k_q         <= '0;
      key_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      k_q         <= k_d;
      key_valid_q <= key_valid_d;
      conflict_q  <= conflict_d;
      start_q     <= start_d;
    end
  end

  assign k         = k_q;
  assign start     = start_q;
  assign key_valid = key_valid_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_b12_keypad_frontend.sv
// Scoreboard bench for b12_keypad_frontend with DEBOUNCE_CYCLES = 4.
module tb_b12_keypad_frontend;

  localparam int D = 4;
  localparam int R = 8;
  localparam int L = D + 3;  // negedges from driving a raw change to seeing the output

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic       start_raw = 1'b0;
  logic [3:0] k;
  logic       start, key_valid, conflict;

  b12_keypad_frontend #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .start_raw(start_raw),
    .k        (k),
    .start    (start),
    .key_valid(key_valid),
    .conflict (conflict)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] k;
    logic       kv;
    logic       cf;
    logic       st;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else    $display("FAIL %s: %s", name, detail);
  endtask

  task automatic expect_ev(input string name, input int rel, input logic [3:0] ek,
                           input logic ekv, input logic ecf, input logic est);
    ev_t e;
    e.name = name;
    e.cyc  = cyc + rel;
    e.k    = ek;
    e.kv   = ekv;
    e.cf   = ecf;
    e.st   = est;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every change of the output bundle must match the next expected event.
  logic [6:0] prev_out = 7'b0;
  always @(negedge clock) begin
    logic [6:0] cur;
    ev_t        e;
    cur = {k, key_valid, conflict, start};
    if (cur !== prev_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", 1'b0,
              $sformatf("cyc=%0d got k=%b kv=%b cf=%b st=%b, required no change",
                        cyc, k, key_valid, conflict, start));
      end else begin
        e = exp_q.pop_front();
        check(e.name, (cur === {e.k, e.kv, e.cf, e.st}) && (cyc == e.cyc),
              $sformatf("got cyc=%0d k=%b kv=%b cf=%b st=%b, required cyc=%0d k=%b kv=%b cf=%b st=%b",
                        cyc, k, key_valid, conflict, start, e.cyc, e.k, e.kv, e.cf, e.st));
      end
      prev_out = cur;
    end
  end

  initial begin
    step(3);
    check("reset_state", {k, key_valid, conflict, start} === 7'b0,
          $sformatf("got k=%b kv=%b cf=%b st=%b, required all 0", k, key_valid, conflict, start));
    reset = 1'b1;
    step(5);

    // Clean press and release
    btn_raw = 4'b0100;
    expect_ev("press_on",      L,     4'b0100, 1'b1, 1'b0, 1'b0);
    expect_ev("press_kv_off",  L + 1, 4'b0100, 1'b0, 1'b0, 1'b0);
    step(6);
    btn_raw = 4'b0000;
    expect_ev("press_release", L,     4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Start level
    start_raw = 1'b1;
    expect_ev("start_on",  L, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(10);
    start_raw = 1'b0;
    expect_ev("start_off", L, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Bounce 1,0,1,0,1 then hold
    for (int i = 0; i < 5; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      if (i != 4) step(1);
    end
    expect_ev("bounce_on",      L,     4'b0001, 1'b1, 1'b0, 1'b0);
    expect_ev("bounce_kv_off",  L + 1, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(6);
    btn_raw = 4'b0000;
    expect_ev("bounce_release", L,     4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Glitch of D-1 cycles is invisible
    btn_raw = 4'b0100;
    step(D - 1);
    btn_raw = 4'b0000;
    step(14);

    // Pulse of exactly D cycles is accepted
    btn_raw = 4'b0100;
    expect_ev("pulse_on",      L,     4'b0100, 1'b1, 1'b0, 1'b0);
    expect_ev("pulse_kv_off",  L + 1, 4'b0100, 1'b0, 1'b0, 1'b0);
    step(D);
    btn_raw = 4'b0000;
    expect_ev("pulse_release", L,     4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Simultaneous press, partial release, full release
    btn_raw = 4'b0011;
    expect_ev("simul_lock",   L, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(10);
    btn_raw = 4'b0010;
    step(12);
    btn_raw = 4'b0000;
    expect_ev("simul_unlock", L, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Swap: second key added while first still held
    btn_raw = 4'b0001;
    expect_ev("swap_first_on", L,     4'b0001, 1'b1, 1'b0, 1'b0);
    expect_ev("swap_kv_off",   L + 1, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(7);
    btn_raw = 4'b1001;
    expect_ev("swap_lock",     L,     4'b0000, 1'b0, 1'b1, 1'b0);
    step(9);
    btn_raw = 4'b0000;
    expect_ev("swap_unlock",   L,     4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Reset while an accepted key is held
    btn_raw = 4'b1000;
    expect_ev("rst_pre_on",     L,     4'b1000, 1'b1, 1'b0, 1'b0);
    expect_ev("rst_pre_kv_off", L + 1, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(10);
    #1 reset = 1'b0;
    #1 check("reset_async", {k, key_valid, conflict, start} === 7'b0,
             $sformatf("got k=%b kv=%b cf=%b st=%b, required all 0", k, key_valid, conflict, start));
    expect_ev("rst_clear", 1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(2);
    reset = 1'b1;
    expect_ev("rst_fresh_on",     L,     4'b1000, 1'b1, 1'b0, 1'b0);
    expect_ev("rst_fresh_kv_off", L + 1, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(6);
    btn_raw = 4'b0000;
    expect_ev("rst_release",      L,     4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    // Long hold: repeats only when the auto-repeat build is selected
    btn_raw = 4'b0010;
    expect_ev("hold_on",     L,     4'b0010, 1'b1, 1'b0, 1'b0);
    expect_ev("hold_kv_off", L + 1, 4'b0010, 1'b0, 1'b0, 1'b0);
`ifdef B12_KEY_AUTOREPEAT_EN
    for (int j = 1; j <= 3; j++) begin
      expect_ev($sformatf("repeat_%0d_on", j),  L + R * j,     4'b0010, 1'b1, 1'b0, 1'b0);
      expect_ev($sformatf("repeat_%0d_off", j), L + R * j + 1, 4'b0010, 1'b0, 1'b0, 1'b0);
    end
`endif
    step(30);
    btn_raw = 4'b0000;
    expect_ev("hold_release", L, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(14);

    check("queue_drained", exp_q.size() == 0,
          $sformatf("got %0d outstanding events, required 0", exp_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
